mems_clk_ctrl: RTL
==================

# mems_clk_ctrl

Clock and capture sequencer for a stereo PDM MEMS microphone pair sharing one data line, driven from the 50 MHz board clock. The block generates the programmable-rate microphone clock and holds the microphones through their power-up settling window. It samples the shared data line at the two clock phases and emits left/right bit pairs with a valid strobe to the downstream decimation filter. It replaces the free-running divider that feeds the microphone clock pin.

## Interface
- `DIV_W`, 8: width of `half_period`.
- `WAKE_CYCLES`, 16384: number of mic-clock rising edges spent in wake-up before data is delivered (≥1).
- `clk` in 1: 50 MHz system clock; all logic on rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `enable` in 1: level request to run the microphones.
- `half_period` in DIV_W: system cycles per mic-clock half period; latched on IDLE→WAKE; value 0 is treated as 1.
- `pdm_data` in 1: shared PDM data line (already synchronised externally).
- `mic_clk` out 1: microphone clock, registered.
- `pdm_left` out 1: left bit of the current pair.
- `pdm_right` out 1: right bit of the current pair.
- `pdm_valid` out 1: one-cycle strobe, pair on `pdm_left`/`pdm_right` is new.
- `ready` out 1: high while in RUN.
- `state` out 2: IDLE=0, WAKE=1, RUN=2, STOP=3.

## Operation
- States:
  - IDLE: `mic_clk`=0 and the half-period counter is held at 0. When `enable`=1, latch `hp = max(half_period,1)` and go to WAKE.
  - WAKE: the clock runs. A 16-bit wake counter counts rising edges of `mic_clk`. When it reaches WAKE_CYCLES, go to RUN in the same cycle as that rising edge. No `pdm_valid` is produced in WAKE.
  - RUN: the clock runs and `pdm_valid` strobes are produced.
  - STOP: the clock continues until it completes a high phase, then the block returns to IDLE.
- Clock generation:
  - The half counter counts 0..hp-1.
  - On the cycle it equals hp-1 ("terminal"), it wraps to 0 and `mic_clk` toggles on the next edge.
  - Mic period is 2·hp system cycles with exactly 50 % duty.
- Capture:
  - At a terminal cycle with `mic_clk`=0 (end of the low phase), register `pdm_data` into the left holding register.
  - At a terminal cycle with `mic_clk`=1 (end of the high phase), register `pdm_data` into `pdm_right`, copy the holding register to `pdm_left`, and, if the state is RUN, assert `pdm_valid` on the next cycle.
  - Pairs begin only after RUN is entered. The first valid pair therefore uses the left bit captured before the rising edge that entered RUN.
- Stop:
  - `enable`=0 in WAKE or RUN moves the block to STOP on the next cycle.
  - In STOP, if `mic_clk`=0, go to IDLE on the next cycle. Otherwise, go to IDLE on the cycle `mic_clk` falls.
  - No `pdm_valid` is produced in STOP.
  - `enable` is ignored in STOP. Re-assertion takes effect only from IDLE.
- `half_period` changes outside IDLE have no effect until the next IDLE→WAKE.
- On wake re-entry, the wake counter restarts from 0.
- Reset, including mid-operation: `state`=IDLE, `mic_clk`=0, `pdm_left`=0, `pdm_right`=0, `pdm_valid`=0, `ready`=0, and all counters 0. Reset takes priority over every other event.

## Timing
- `mic_clk` first rises hp cycles after the cycle WAKE is entered.
- `pdm_valid` is high for exactly 1 cycle per mic period. Successive strobes are 2·hp cycles apart in steady state.
- Latency from the right-bit sample cycle to `pdm_valid`/data is 1 cycle. `pdm_left`/`pdm_right` are stable between strobes.
- `ready` and `state` are registered and change on the cycle after the decision.
- Minimum period is hp=1, giving a 25 MHz `mic_clk` and a valid every 2 cycles. All outputs remain correct at this rate.
- If `enable` falls on the same cycle as the wake counter reaching WAKE_CYCLES, STOP wins.
- If `enable` falls on the cycle a RUN pair completes, that strobe is still issued.

## Test plan
- Reset/idle:
  - Stimulus: hold `rst`=1 with `enable`=1 for 5 cycles, then release `rst` and drop `enable`.
  - Required: all outputs are 0, `state`=0, and `mic_clk` stays 0 for 100 cycles.
- Wake sequence:
  - Stimulus: WAKE_CYCLES=4, `half_period`=3, raise `enable`.
  - Required: `mic_clk` has period 6 and first rises 3 cycles after WAKE. `ready` rises after the 4th rising edge. No `pdm_valid` occurs before then.
- Capture:
  - Stimulus: in RUN with hp=3, drive `pdm_data`=1 during the low phase and 0 during the high phase.
  - Required: every `pdm_valid` shows `pdm_left`=1 and `pdm_right`=0, with strobes spaced 6 cycles.
- Stop mid-high-phase:
  - Stimulus: drop `enable` 1 cycle after `mic_clk` rises.
  - Required: `state`=3 next cycle, `mic_clk` falls on its normal schedule, IDLE follows, and there is no valid in STOP.
- Divider edge cases:
  - Stimulus: `half_period`=0, then change `half_period` to 10 while in RUN.
  - Required: `mic_clk` period is 2 cycles, unchanged until a stop/restart, after which the period is 20 cycles.
- Reset mid-RUN:
  - Stimulus: assert `rst` for 1 cycle during the `mic_clk` high phase.
  - Required: the next cycle shows IDLE, `mic_clk`=0 and `pdm_valid`=0. Re-enable repeats the full wake-up count.

Source files
------------

// File: rtl/mems_clk_ctrl.sv
// mems_clk_ctrl: mic-clock generator and stereo PDM capture sequencer.
// The microphone clock runs at clk / (2*hp). After power-up the clock is held
// running for WAKE_CYCLES rising edges before any left/right pairs are delivered.
// On stop, the clock is allowed to finish its high phase before it is parked low.
module mems_clk_ctrl #(
    parameter int DIV_W       = 8,
    parameter int WAKE_CYCLES = 16384
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [DIV_W-1:0] half_period,
    input  logic             pdm_data,
    output logic             mic_clk,
    output logic             pdm_left,
    output logic             pdm_right,
    output logic             pdm_valid,
    output logic             ready,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAKE = 2'd1,
        RUN  = 2'd2,
        STOP = 2'd3
    } state_t;

    localparam logic [15:0] WAKE_LAST = 16'(WAKE_CYCLES - 1);

    state_t           state_q;
    state_t           next_state;
    logic [DIV_W-1:0] hp;
    logic [DIV_W-1:0] half_cnt;
    logic [15:0]      wake_cnt;
    logic             left_hold;
    logic             terminal;
    logic             rise;
    logic             fall;

    assign state = state_q;

    // Divider phase decode and next-state selection.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        next_state = state_q;
        terminal   = (half_cnt == hp - DIV_W'(1));
        rise       = terminal && !mic_clk;
        fall       = terminal && mic_clk;
        case (state_q)
            IDLE: if (enable) next_state = WAKE;
            // A stop request beats the wake-complete edge.
            WAKE: begin
                if (!enable)                          next_state = STOP;
                else if (rise && wake_cnt == WAKE_LAST) next_state = RUN;
            end
            RUN:  if (!enable) next_state = STOP;
            // Leave immediately if low, else on the cycle the clock falls.
            STOP: if (!mic_clk || terminal) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every
        // process sees the pre-edge value during this cycle.
        if (rst) state_q <= IDLE;
        else     state_q <= next_state;
    end

    // Divider, wake counter, capture path and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            hp        <= '0;
            half_cnt  <= '0;
            mic_clk   <= 1'b0;
            wake_cnt  <= '0;
            left_hold <= 1'b0;
            pdm_left  <= 1'b0;
            pdm_right <= 1'b0;
            pdm_valid <= 1'b0;
            ready     <= 1'b0;
        end else begin
            pdm_valid <= 1'b0;
            ready     <= (next_state == RUN);
            if (state_q == IDLE) begin
                half_cnt <= '0;
                mic_clk  <= 1'b0;
                wake_cnt <= '0;
                if (enable)
                    hp <= (half_period == '0) ? DIV_W'(1) : half_period;
            end else if (next_state == IDLE) begin
                // Leaving STOP: park the clock low with the divider cleared.
                half_cnt <= '0;
                mic_clk  <= 1'b0;
            end else begin
                if (terminal) begin
                    half_cnt <= '0;
                    mic_clk  <= ~mic_clk;
                end else begin
                    half_cnt <= half_cnt + DIV_W'(1);
                end
                if (rise) begin
                    left_hold <= pdm_data;
                    if (state_q == WAKE) wake_cnt <= wake_cnt + 16'd1;
                end
                // Pairs are only published in RUN so outputs hold between strobes.
                if (fall && state_q == RUN) begin
                    pdm_right <= pdm_data;
                    pdm_left  <= left_hold;
                    pdm_valid <= 1'b1;
                end
            end
        end
    end

endmodule
